// File: rtl/yarvi_alu_issue.sv
// Issue stage ahead of the ALU: decodes one instruction into ALU controls,
// forwards EX/WB results, interlocks on load-use, and holds one output slot.
module yarvi_alu_issue #(
  parameter int unsigned XMSB = 31
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [XMSB:0]   in_pc,
  input  logic [XMSB:0]   rs1_val,
  input  logic [XMSB:0]   rs2_val,
  input  logic            flush,
  input  logic [XMSB:0]   ex_result,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XMSB:0]   wb_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_insn30,
  output logic [2:0]      out_funct3,
  output logic [XMSB:0]   out_op1,
  output logic [XMSB:0]   out_op2,
  output logic [XMSB:0]   out_store_data,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic [2:0]      out_kind,
  output logic            out_illegal
);
  localparam int unsigned XLEN = XMSB + 1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;

  localparam logic IDLE = 1'b0;
  localparam logic PEND = 1'b1;

  logic [6:0]    opc;
  logic [2:0]    f3;
  logic [4:0]    rs1, rs2, rd;
  logic [XMSB:0] imm_i, imm_s, imm_u;
  logic [XMSB:0] fwd1, fwd2;
  logic          uses1, uses2, haz1, haz2, stall, accept;
  logic          state, state_n;
  logic [4:0]    pend_rd, pend_rd_n;
  logic          wb_hits_pend, load_leaves, ex_fwd_ok;

  logic          d_insn30, d_wr, d_illegal;
  logic [2:0]    d_funct3, d_kind;
  logic [XMSB:0] d_op1, d_op2, d_sd;

  assign opc   = in_insn[6:0];
  assign f3    = in_insn[14:12];
  assign rd    = in_insn[11:7];
  assign rs1   = in_insn[19:15];
  assign rs2   = in_insn[24:20];
  assign imm_i = XLEN'($signed(in_insn[31:20]));
  assign imm_s = XLEN'($signed({in_insn[31:25], in_insn[11:7]}));
  assign imm_u = XLEN'($signed({in_insn[31:12], 12'h000}));

  // Operand forwarding: EX result of the slot beats writeback beats the register file
  assign ex_fwd_ok = out_valid & out_we & ~out_kind[2];
  always_comb begin
    fwd1 = rs1_val;
    fwd2 = rs2_val;
    if (rs1 == 5'd0)                     fwd1 = '0;
    else if (ex_fwd_ok && out_rd == rs1) fwd1 = ex_result;
    else if (wb_we && wb_rd == rs1)      fwd1 = wb_val;
    if (rs2 == 5'd0)                     fwd2 = '0;
    else if (ex_fwd_ok && out_rd == rs2) fwd2 = ex_result;
    else if (wb_we && wb_rd == rs2)      fwd2 = wb_val;
  end

  // Decode into ALU controls and source usage
  always_comb begin
    d_insn30  = 1'b0;
    d_funct3  = F3_ADD;
    d_op1     = '0;
    d_op2     = '0;
    d_sd      = '0;
    d_wr      = 1'b0;
    d_kind    = 3'b000;
    d_illegal = 1'b0;
    uses1     = 1'b0;
    uses2     = 1'b0;
    case (opc)
      OPC_OP: begin
        d_op1 = fwd1; d_op2 = fwd2; d_funct3 = f3; d_wr = 1'b1;
        d_insn30 = in_insn[30] & ((f3 == 3'b000) | (f3 == 3'b101));
        uses1 = 1'b1; uses2 = 1'b1;
      end
      OPC_OP_IMM: begin
        d_op1 = fwd1; d_funct3 = f3; d_wr = 1'b1; uses1 = 1'b1;
        // shifts carry only the shift amount; bit 30 selects arithmetic
        d_op2 = (f3[1:0] == 2'b01) ? XLEN'(in_insn[24:20]) : imm_i;
        d_insn30 = in_insn[30] & (f3 == 3'b101);
      end
      OPC_LUI:   begin d_op2 = imm_u; d_wr = 1'b1; end
      OPC_AUIPC: begin d_op1 = in_pc; d_op2 = imm_u; d_wr = 1'b1; end
      OPC_JAL, OPC_JALR: begin d_op1 = in_pc; d_op2 = XLEN'(4); d_wr = 1'b1; end
      OPC_LOAD: begin
        d_op1 = fwd1; d_op2 = imm_i; d_wr = 1'b1; d_kind = 3'b100; uses1 = 1'b1;
      end
      OPC_STORE: begin
        d_op1 = fwd1; d_op2 = imm_s; d_sd = fwd2; d_kind = 3'b010;
        uses1 = 1'b1; uses2 = 1'b1;
      end
      OPC_BRANCH: begin
        d_op1 = fwd1; d_op2 = fwd2; d_kind = 3'b001; uses1 = 1'b1; uses2 = 1'b1;
        case (f3[2:1])
          2'b10:   d_funct3 = F3_SLT;
          2'b11:   d_funct3 = F3_SLTU;
          default: d_funct3 = F3_XOR;
        endcase
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // Load-use interlock against the slot load and the outstanding load
  assign wb_hits_pend = wb_we & (wb_rd == pend_rd);
  assign haz1 = uses1 & (rs1 != 5'd0) &
                ((out_valid & out_kind[2] & (out_rd == rs1)) |
                 ((state == PEND) & (pend_rd == rs1) & ~wb_hits_pend));
  assign haz2 = uses2 & (rs2 != 5'd0) &
                ((out_valid & out_kind[2] & (out_rd == rs2)) |
                 ((state == PEND) & (pend_rd == rs2) & ~wb_hits_pend));
  assign stall    = in_valid & (haz1 | haz2);
  assign in_ready = flush | ((~out_valid | out_ready) & ~stall);
  assign accept   = in_valid & in_ready;

  // Load FSM next state; a newer departing load replaces the tracked one
  assign load_leaves = out_valid & out_ready & ~flush & out_kind[2] & (out_rd != 5'd0);
  always_comb begin
    state_n   = state;
    pend_rd_n = pend_rd;
    case (state)
      IDLE: if (load_leaves) begin state_n = PEND; pend_rd_n = out_rd; end
      PEND: begin
        if (load_leaves)       pend_rd_n = out_rd;
        else if (wb_hits_pend) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Load FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pend_rd <= 5'd0;
    end else begin
      state   <= state_n;
      pend_rd <= pend_rd_n;
    end
  end

  // Output slot: flush drops, accept loads, consumption empties
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_insn30     <= 1'b0;
      out_funct3     <= 3'b000;
      out_op1        <= '0;
      out_op2        <= '0;
      out_store_data <= '0;
      out_rd         <= 5'd0;
      out_we         <= 1'b0;
      out_kind       <= 3'b000;
      out_illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_insn30     <= d_insn30;
      out_funct3     <= d_funct3;
      out_op1        <= d_op1;
      out_op2        <= d_op2;
      out_store_data <= d_sd;
      out_rd         <= d_wr ? rd : 5'd0;
      out_we         <= d_wr & (rd != 5'd0);
      out_kind       <= d_kind;
      out_illegal    <= d_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_yarvi_alu_issue.sv
// Bench for yarvi_alu_issue: decode vector table, hand-written hazard/handshake
// sequences, and randomized traffic against a behavioural model.
module tb_yarvi_alu_issue;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, wb_we, out_valid, out_ready;
  logic [31:0] in_insn, in_pc, rs1_val, rs2_val, ex_result, wb_val;
  logic [4:0]  wb_rd, out_rd;
  logic        out_insn30, out_we, out_illegal;
  logic [2:0]  out_funct3, out_kind;
  logic [31:0] out_op1, out_op2, out_store_data;

  always #5 clock = ~clock;

  yarvi_alu_issue #(.XMSB(31)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .flush(flush), .ex_result(ex_result), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_val(wb_val), .out_valid(out_valid), .out_ready(out_ready),
    .out_insn30(out_insn30), .out_funct3(out_funct3), .out_op1(out_op1),
    .out_op2(out_op2), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_we(out_we), .out_kind(out_kind), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] insn, pc, r1, r2;
    logic        i30;
    logic [2:0]  f3;
    logic [31:0] op1, op2, sd;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  kind;
    logic        ill;
  } vec_t;

  typedef struct {
    logic        v;
    logic        i30;
    logic [2:0]  f3;
    logic [31:0] op1, op2, sd;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  kind;
    logic        ill;
  } slot_t;

  int    n_checks = 0;
  int    n_pass   = 0;
  vec_t  vecs[15];
  slot_t m;
  logic        m_pend;
  logic [4:0]  m_pend_rd;
  logic [2:0]  br_f3s[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid = 1'b0; in_insn = 32'h0; in_pc = 32'h0; rs1_val = 32'h0; rs2_val = 32'h0;
    flush = 1'b0; ex_result = 32'h0; wb_we = 1'b0; wb_rd = 5'd0; wb_val = 32'h0;
    out_ready = 1'b1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drive(input logic [31:0] insn, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1; in_insn = insn; in_pc = pc; rs1_val = r1; rs2_val = r2;
  endtask

  function automatic logic [31:0] sext12(input logic [11:0] x);
    return {{20{x[11]}}, x};
  endfunction

  // Reference decode from the instruction-set rules, operands already forwarded
  function automatic slot_t model_decode(input logic [31:0] insn, input logic [31:0] pc,
                                         input logic [31:0] a, input logic [31:0] b);
    slot_t s;
    logic  wr;
    logic [2:0] f3;
    s = '{default: '0};
    wr = 1'b0;
    f3 = insn[14:12];
    case (insn[6:0])
      7'h33: begin s.op1 = a; s.op2 = b; s.f3 = f3; wr = 1'b1;
                   s.i30 = insn[30] && (f3 == 3'd0 || f3 == 3'd5); end
      7'h13: begin s.op1 = a; s.f3 = f3; wr = 1'b1;
                   s.op2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, insn[24:20]} : sext12(insn[31:20]);
                   s.i30 = insn[30] && f3 == 3'd5; end
      7'h37: begin s.op2 = {insn[31:12], 12'h0}; wr = 1'b1; end
      7'h17: begin s.op1 = pc; s.op2 = {insn[31:12], 12'h0}; wr = 1'b1; end
      7'h6F, 7'h67: begin s.op1 = pc; s.op2 = 32'd4; wr = 1'b1; end
      7'h03: begin s.op1 = a; s.op2 = sext12(insn[31:20]); s.kind = 3'b100; wr = 1'b1; end
      7'h23: begin s.op1 = a; s.op2 = sext12({insn[31:25], insn[11:7]}); s.sd = b;
                   s.kind = 3'b010; end
      7'h63: begin s.op1 = a; s.op2 = b; s.kind = 3'b001;
                   s.f3 = (f3 < 3'd2) ? 3'd4 : (f3 < 3'd6) ? 3'd2 : 3'd3; end
      default: s.ill = 1'b1;
    endcase
    s.rd = wr ? insn[11:7] : 5'd0;
    s.we = wr && insn[11:7] != 5'd0;
    return s;
  endfunction

  function automatic logic m_uses1(input logic [6:0] o);
    return o == 7'h33 || o == 7'h13 || o == 7'h03 || o == 7'h23 || o == 7'h63;
  endfunction

  function automatic logic m_uses2(input logic [6:0] o);
    return o == 7'h33 || o == 7'h23 || o == 7'h63;
  endfunction

  function automatic logic m_hazard(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return (m.v && m.kind[2] && m.rd == r) ||
           (m_pend && m_pend_rd == r && !(wb_we && wb_rd == m_pend_rd));
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return 32'd0;
    if (m.v && m.we && !m.kind[2] && m.rd == r) return ex_result;
    if (wb_we && wb_rd == r) return wb_val;
    return rf;
  endfunction

  task automatic check_slot(input string tag, input slot_t e);
    check({tag, "_insn30"}, out_insn30, e.i30);
    check({tag, "_funct3"}, out_funct3, e.f3);
    check({tag, "_op1"},    out_op1,    e.op1);
    check({tag, "_op2"},    out_op2,    e.op2);
    check({tag, "_sd"},     out_store_data, e.sd);
    check({tag, "_rd"},     out_rd,     e.rd);
    check({tag, "_we"},     out_we,     e.we);
    check({tag, "_kind"},   out_kind,   e.kind);
    check({tag, "_ill"},    out_illegal, e.ill);
  endtask

  initial begin
    slot_t e;
    logic [31:0] held_op1, held_op2;

    br_f3s[0] = 3'd0; br_f3s[1] = 3'd1; br_f3s[2] = 3'd4;
    br_f3s[3] = 3'd5; br_f3s[4] = 3'd6; br_f3s[5] = 3'd7;
    //          insn          pc          r1          r2          i30   f3    op1           op2           sd          rd     we    kind    ill
    vecs[0]  = '{32'hFFF00093, 32'h1000, 32'h1234, 32'h5678, 1'b0, 3'd0, 32'h0,        32'hFFFFFFFF, 32'h0,      5'd1,  1'b1, 3'b000, 1'b0};
    vecs[1]  = '{32'h4030D113, 32'h1000, 32'h80,   32'h5678, 1'b1, 3'd5, 32'h80,       32'h3,        32'h0,      5'd2,  1'b1, 3'b000, 1'b0};
    vecs[2]  = '{32'h40008193, 32'h1000, 32'h80,   32'h5678, 1'b0, 3'd0, 32'h80,       32'h400,      32'h0,      5'd3,  1'b1, 3'b000, 1'b0};
    vecs[3]  = '{32'h407302B3, 32'h1000, 32'h80,   32'h5678, 1'b1, 3'd0, 32'h80,       32'h5678,     32'h0,      5'd5,  1'b1, 3'b000, 1'b0};
    vecs[4]  = '{32'h80000437, 32'h1000, 32'h80,   32'h5678, 1'b0, 3'd0, 32'h0,        32'h80000000, 32'h0,      5'd8,  1'b1, 3'b000, 1'b0};
    vecs[5]  = '{32'h12345497, 32'h1000, 32'h80,   32'h5678, 1'b0, 3'd0, 32'h1000,     32'h12345000, 32'h0,      5'd9,  1'b1, 3'b000, 1'b0};
    vecs[6]  = '{32'h000000EF, 32'h1000, 32'h80,   32'h5678, 1'b0, 3'd0, 32'h1000,     32'h4,        32'h0,      5'd1,  1'b1, 3'b000, 1'b0};
    vecs[7]  = '{32'h00008067, 32'h1000, 32'h80,   32'h5678, 1'b0, 3'd0, 32'h1000,     32'h4,        32'h0,      5'd0,  1'b0, 3'b000, 1'b0};
    vecs[8]  = '{32'h00208063, 32'h1000, 32'h80,   32'h5678, 1'b0, 3'd4, 32'h80,       32'h5678,     32'h0,      5'd0,  1'b0, 3'b001, 1'b0};
    vecs[9]  = '{32'h0020C063, 32'h1000, 32'h80,   32'h5678, 1'b0, 3'd2, 32'h80,       32'h5678,     32'h0,      5'd0,  1'b0, 3'b001, 1'b0};
    vecs[10] = '{32'h0020F063, 32'h1000, 32'h80,   32'h5678, 1'b0, 3'd3, 32'h80,       32'h5678,     32'h0,      5'd0,  1'b0, 3'b001, 1'b0};
    vecs[11] = '{32'h00512423, 32'h1000, 32'h80,   32'h5678, 1'b0, 3'd0, 32'h80,       32'h8,        32'h5678,   5'd0,  1'b0, 3'b010, 1'b0};
    vecs[12] = '{32'hFE002FA3, 32'h1000, 32'h80,   32'h5678, 1'b0, 3'd0, 32'h0,        32'hFFFFFFFF, 32'h0,      5'd0,  1'b0, 3'b010, 1'b0};
    vecs[13] = '{32'hFFFFFFFF, 32'h1000, 32'h80,   32'h5678, 1'b0, 3'd0, 32'h0,        32'h0,        32'h0,      5'd0,  1'b0, 3'b000, 1'b1};
    vecs[14] = '{32'hFFC12203, 32'h1000, 32'h80,   32'h5678, 1'b0, 3'd0, 32'h80,       32'hFFFFFFFC, 32'h0,      5'd4,  1'b1, 3'b100, 1'b0};

    // Reset state
    do_reset();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_op1", out_op1, 32'h0);
    check("rst_op2", out_op2, 32'h0);
    check("rst_rd_we_kind", {out_rd, out_we, out_kind, out_illegal}, 32'h0);
    check("rst_in_ready", in_ready, 1'b1);

    // Decode table, one instruction at a time through an empty slot
    foreach (vecs[i]) begin
      drive(vecs[i].insn, vecs[i].pc, vecs[i].r1, vecs[i].r2);
      #3 check($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
      step();
      check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      e = '{1'b1, vecs[i].i30, vecs[i].f3, vecs[i].op1, vecs[i].op2, vecs[i].sd,
            vecs[i].rd, vecs[i].we, vecs[i].kind, vecs[i].ill};
      check_slot($sformatf("vec%0d", i), e);
      in_valid = 1'b0;
      step();
    end

    // EX forwarding beats WB and register file
    do_reset();
    drive(32'hFFF00093, 32'h0, 32'h0, 32'h0);
    step();
    drive(32'h001081B3, 32'h0, 32'h33, 32'h33);
    ex_result = 32'h5; wb_we = 1'b1; wb_rd = 5'd1; wb_val = 32'h99;
    #3 check("exfwd_in_ready", in_ready, 1'b1);
    step();
    check("exfwd_op1", out_op1, 32'h5);
    check("exfwd_op2", out_op2, 32'h5);
    check("exfwd_rd", out_rd, 5'd3);
    in_valid = 1'b0;
    step();
    // Slot empty now: WB beats register file
    drive(32'h001081B3, 32'h0, 32'h33, 32'h33);
    step();
    check("wbfwd_op1", out_op1, 32'h99);
    check("wbfwd_op2", out_op2, 32'h99);
    in_valid = 1'b0; wb_we = 1'b0;
    step();

    // Load-use: stall until the load's writeback, then forward it
    do_reset();
    drive(32'h0000A203, 32'h0, 32'h10, 32'h0);
    step();
    drive(32'h000202B3, 32'h0, 32'h11, 32'h22);
    #3 check("ldu_slot_stall", in_ready, 1'b0);
    step();
    check("ldu_slot_drained", out_valid, 1'b0);
    for (int k = 0; k < 2; k++) begin
      #3 check($sformatf("ldu_pend_stall%0d", k), in_ready, 1'b0);
      step();
    end
    wb_we = 1'b1; wb_rd = 5'd4; wb_val = 32'h77;
    #3 check("ldu_wb_release", in_ready, 1'b1);
    step();
    check("ldu_valid", out_valid, 1'b1);
    check("ldu_op1", out_op1, 32'h77);
    check("ldu_op2", out_op2, 32'h0);
    check("ldu_rd", out_rd, 5'd5);
    in_valid = 1'b0; wb_we = 1'b0;
    step();

    // Back-pressure holds the slot; flush then empties it
    drive(32'h407302B3, 32'h0, 32'hA, 32'hB);
    step();
    held_op1 = out_op1;
    held_op2 = out_op2;
    check("hold_op1_init", held_op1, 32'hA);
    out_ready = 1'b0;
    drive(32'h80000437, 32'h0, 32'h1, 32'h2);
    for (int k = 0; k < 3; k++) begin
      #3 check($sformatf("hold_in_ready%0d", k), in_ready, 1'b0);
      step();
      check($sformatf("hold_valid%0d", k), out_valid, 1'b1);
      check($sformatf("hold_ops%0d", k), {out_op1[15:0], out_op2[15:0]}, {held_op1[15:0], held_op2[15:0]});
      check($sformatf("hold_ctl%0d", k), {out_insn30, out_funct3, out_rd}, {1'b1, 3'd0, 5'd5});
    end
    flush = 1'b1;
    #3 check("flush_in_ready", in_ready, 1'b1);
    step();
    check("flush_valid", out_valid, 1'b0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();

    // Reset while stalled on an outstanding load clears the interlock
    drive(32'h0000A203, 32'h0, 32'h10, 32'h0);
    step();
    drive(32'h000202B3, 32'h0, 32'h11, 32'h22);
    step();
    #3 check("rststall_pre", in_ready, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rststall_valid", out_valid, 1'b0);
    #3 check("rststall_ready", in_ready, 1'b1);
    step();
    check("rststall_op1", out_op1, 32'h11);
    in_valid = 1'b0;

    // Randomized traffic against the behavioural model
    do_reset();
    m = '{default: '0};
    m_pend = 1'b0;
    m_pend_rd = 5'd0;
    for (int it = 0; it < 3000; it++) begin
      slot_t pred;
      logic [6:0] o;
      logic stall_m, rdy_m, leave;
      logic [31:0] a, b, ins;
      int sel;
      sel = $urandom_range(0, 8);
      case (sel)
        0: o = 7'h33; 1: o = 7'h13; 2: o = 7'h37; 3: o = 7'h17; 4: o = 7'h6F;
        5: o = 7'h03; 6: o = 7'h23; 7: o = 7'h63; default: o = 7'h0B;
      endcase
      ins = $urandom;
      ins[6:0]   = o;
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      if (o == 7'h63) ins[14:12] = br_f3s[$urandom_range(0, 5)];
      in_insn   = ins;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = $urandom;
      rs1_val   = $urandom;
      rs2_val   = $urandom;
      flush     = ($urandom_range(0, 19) == 0);
      ex_result = $urandom;
      wb_we     = ($urandom_range(0, 4) < 2);
      wb_rd     = 5'($urandom_range(0, 3));
      wb_val    = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);

      stall_m = in_valid && ((m_uses1(o) && m_hazard(ins[19:15])) ||
                             (m_uses2(o) && m_hazard(ins[24:20])));
      rdy_m = flush || ((!m.v || out_ready) && !stall_m);
      #3 check("rnd_in_ready", in_ready, rdy_m);

      a = m_fwd(ins[19:15], rs1_val);
      b = m_fwd(ins[24:20], rs2_val);
      pred = model_decode(ins, in_pc, a, b);
      leave = m.v && out_ready && !flush && m.kind[2] && m.rd != 5'd0;
      if (leave) begin
        m_pend = 1'b1;
        m_pend_rd = m.rd;
      end else if (m_pend && wb_we && wb_rd == m_pend_rd) begin
        m_pend = 1'b0;
      end
      if (flush) m.v = 1'b0;
      else if (in_valid && rdy_m) begin m = pred; m.v = 1'b1; end
      else if (out_ready) m.v = 1'b0;

      step();
      check("rnd_valid", out_valid, m.v);
      if (m.v) check_slot("rnd", m);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
